// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;
  typedef enum logic [1:0] {OFF, SHOW, GAP} scan_state_e;

  localparam int BCD_W   = 4;
  localparam int MAX_DIG = 8;
  localparam logic [MAX_DIG-1:0] ANODE_OFF = '1;
endpackage

// File: rtl/seg_scan_timer.sv
// Slot/gap cycle counter for the scan controller; flags the last cycle of each phase.
module seg_scan_timer #(
  parameter int DIV     = 50000,
  parameter int GAP_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic in_gap,
  output logic slot_done,
  output logic gap_done
);
  localparam int CMAX = (DIV > GAP_CYC) ? DIV : GAP_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  logic [CW-1:0] cnt;

  assign slot_done = !in_gap && (cnt == DIV_LAST);
  assign gap_done  =  in_gap && (cnt == GAP_LAST);

  // Held at zero while idle so the first SHOW cycle always starts from 0.
  always_ff @(posedge clk) begin
    if (rst || !run || slot_done || gap_done) cnt <= '0;
    else                                      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit register file plus OFF/SHOW/GAP scan FSM driving a shared BCD decoder.
// Define SEG_SCAN_LZB_EN to blank leading zeros (digit 0 always lit).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG    = 8,
  parameter int DIV     = 50000,
  parameter int GAP_CYC = 2,
  localparam int IW     = $clog2(NDIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [3:0]       wr_data,
  output logic [BCD_W-1:0] bcd,
  output logic [NDIG-1:0]  an,
  output logic             frame_tick
);
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  scan_state_e state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic ft_nxt;
  logic [NDIG-1:0][BCD_W-1:0] digit;
  logic [BCD_W-1:0] cur;
  logic lit, run, slot_done, gap_done;

  assign run = en && (state != OFF);

  seg_scan_timer #(.DIV(DIV), .GAP_CYC(GAP_CYC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .in_gap    (state == GAP),
    .slot_done (slot_done),
    .gap_done  (gap_done)
  );

  always_comb begin
    cur = '0;
    for (int i = 0; i < NDIG; i++)
      if (idx == IW'(i)) cur = digit[i];
  end

`ifdef SEG_SCAN_LZB_EN
  // Lit if this digit or any more-significant digit is non-zero.
  always_comb begin
    lit = (idx == '0);
    for (int i = 0; i < NDIG; i++)
      if (IW'(i) >= idx && digit[i] != '0) lit = 1'b1;
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ft_nxt    = 1'b0;
    bcd       = '0;
    an        = ANODE_OFF[NDIG-1:0];
    unique case (state)
      OFF: if (en) begin
        state_nxt = SHOW;
        idx_nxt   = '0;
        ft_nxt    = 1'b1;
      end
      SHOW: begin
        bcd = cur;
        if (lit) an = ~(NDIG'(1) << idx);
        if (slot_done) state_nxt = GAP;
      end
      GAP: begin
        bcd = cur;
        if (gap_done) begin
          state_nxt = SHOW;
          idx_nxt   = (idx == LAST) ? '0 : idx + 1'b1;
          ft_nxt    = (idx == LAST);
        end
      end
      default: state_nxt = OFF;
    endcase
    // Disable wins over any counter expiry in the same cycle.
    if (!en) begin
      state_nxt = OFF;
      idx_nxt   = '0;
      ft_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      idx        <= '0;
      frame_tick <= 1'b0;
      digit      <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      frame_tick <= ft_nxt;
      for (int i = 0; i < NDIG; i++)
        if (wr_en && wr_idx == IW'(i)) digit[i] <= wr_data;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, corner sequences, random vs. frame-time model.
module tb_seg_scan_ctrl;
  localparam int NDIG = 4, DIV = 4, GAPC = 1;
  localparam int SLOT = DIV + GAPC, FRAME = NDIG * SLOT;

  logic clk = 1'b0;
  logic rst, en, wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_data, bcd;
  logic [NDIG-1:0] an;
  logic frame_tick;

  logic rst5, en5, wr_en5;
  logic [2:0] wr_idx5;
  logic [3:0] wr_data5, bcd5;
  logic [4:0] an5;
  logic ft5;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP_CYC(GAPC)) u_dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .bcd(bcd), .an(an), .frame_tick(frame_tick));

  seg_scan_ctrl #(.NDIG(5), .DIV(2), .GAP_CYC(1)) u_dut5 (
    .clk(clk), .rst(rst5), .en(en5), .wr_en(wr_en5), .wr_idx(wr_idx5),
    .wr_data(wr_data5), .bcd(bcd5), .an(an5), .frame_tick(ft5));

  int n_chk = 0, n_fail = 0;

  // Model: frame position m_t counts cycles since the first lit cycle of the frame.
  int m_dig[NDIG];
  bit m_on;
  int m_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int slot, ph, ea, eb, ef;
    bit lit;
    ea = 15; eb = 0; ef = 0;
    if (m_on) begin
      slot = m_t / SLOT;
      ph   = m_t % SLOT;
      eb   = m_dig[slot];
      ef   = (m_t == 0) ? 1 : 0;
      lit  = 1'b1;
`ifdef SEG_SCAN_LZB_EN
      lit = (slot == 0);
      for (int j = slot; j < NDIG; j++) if (m_dig[j] != 0) lit = 1'b1;
`endif
      if (ph < DIV && lit) ea = 15 & ~(1 << slot);
    end
    chk("model_an", 32'(an), 32'(ea));
    chk("model_bcd", 32'(bcd), 32'(eb));
    chk("model_tick", 32'(frame_tick), 32'(ef));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      foreach (m_dig[i]) m_dig[i] = 0;
      m_on = 1'b0; m_t = 0;
    end else begin
      if (wr_en && int'(wr_idx) < NDIG) m_dig[wr_idx] = int'(wr_data);
      if (!en) begin m_on = 1'b0; m_t = 0; end
      else if (!m_on) begin m_on = 1'b1; m_t = 0; end
      else m_t = (m_t + 1) % FRAME;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic adv_until(int tgt);
    int k = 0;
    while (!(m_on && m_t == tgt) && k < 2 * FRAME) begin step(); k++; end
    chk("reach_frame_pos", 32'(m_t), 32'(tgt));
  endtask

  typedef struct {
    logic rst, en, wr_en;
    logic [1:0] widx;
    logic [3:0] wdat, an, bcd;
    logic ft;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit w, int wi, int wd, int a, int b, bit f);
    vec_t v;
    v.rst = r; v.en = e; v.wr_en = w; v.widx = 2'(wi); v.wdat = 4'(wd);
    v.an = 4'(a); v.bcd = 4'(b); v.ft = f;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int last_tick, ticks, k;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    rst5 = 1'b1; en5 = 1'b0; wr_en5 = 1'b0; wr_idx5 = '0; wr_data5 = '0;
    foreach (m_dig[i]) m_dig[i] = 0;
    m_on = 1'b0; m_t = 0;

    // NDIG=5 instance: out-of-range indices 5..7 must leave the file untouched.
    @(negedge clk); @(negedge clk);
    rst5 = 1'b0;
    chk("n5_reset_an", 32'(an5), 32'h1f);
    wr_en5 = 1'b1;
    wr_idx5 = 3'd7; wr_data5 = 4'd9; @(negedge clk);
    wr_idx5 = 3'd5; wr_data5 = 4'd8; @(negedge clk);
    wr_idx5 = 3'd6; wr_data5 = 4'd2; @(negedge clk);
    wr_idx5 = 3'd4; wr_data5 = 4'd6; @(negedge clk);
    wr_en5 = 1'b0; en5 = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      chk("n5_bcd", 32'(bcd5), 32'((t / 3 == 4) ? 6 : 0));
      chk("n5_an", 32'(an5), 32'((t % 3 < 2) ? (31 & ~(1 << (t / 3))) : 31));
    end
    en5 = 1'b0; rst5 = 1'b1;

    // Vector table: reset, load 3,1,4,1, enable, first slots.
    tbl[0]  = mk(1, 0, 0, 0, 0, 'hF, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 3, 'hF, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 1, 'hF, 0, 0);
    tbl[3]  = mk(0, 0, 1, 2, 4, 'hF, 0, 0);
    tbl[4]  = mk(0, 0, 1, 3, 1, 'hF, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 'hE, 3, 1);
    tbl[6]  = mk(0, 1, 0, 0, 0, 'hE, 3, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 'hE, 3, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 'hE, 3, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 'hF, 3, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 'hD, 1, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 'hD, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 'hD, 1, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 'hD, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 'hF, 1, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 'hB, 4, 0);
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; wr_en = tbl[i].wr_en;
      wr_idx = tbl[i].widx; wr_data = tbl[i].wdat;
      step();
      chk("vec_an", 32'(an), 32'(tbl[i].an));
      chk("vec_bcd", 32'(bcd), 32'(tbl[i].bcd));
      chk("vec_tick", 32'(frame_tick), 32'(tbl[i].ft));
    end
    rst = 1'b0; wr_en = 1'b0;

    // frame_tick spacing over two frames.
    last_tick = -1; ticks = 0; k = 0;
    while (ticks < 2 && k < 3 * FRAME) begin
      step(); k++;
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) chk("tick_period", 32'(k - last_tick), 32'(FRAME));
        last_tick = k; ticks++;
      end
    end
    chk("tick_count", 32'(ticks), 32'd2);

    // Disable mid-slot of digit 2, then restart.
    adv_until(2 * SLOT + 1);
    en = 1'b0; step();
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_bcd", 32'(bcd), 32'h0);
    en = 1'b1; step();
    chk("reen_an", 32'(an), 32'hE);
    chk("reen_bcd", 32'(bcd), 32'h3);
    chk("reen_tick", 32'(frame_tick), 32'h1);

    // Write the digit currently displayed.
    adv_until(SLOT + 1);
    chk("live_pre", 32'(bcd), 32'h1);
    wr_en = 1'b1; wr_idx = 2'd1; wr_data = 4'd7; step();
    wr_en = 1'b0;
    chk("live_bcd", 32'(bcd), 32'h7);
    chk("live_an", 32'(an), 32'hD);
    step();
    chk("live_slot_kept", 32'(an), 32'hD);
    step();
    chk("live_gap", 32'(an), 32'hF);

    // Reset during a gap clears everything.
    adv_until(2 * SLOT + DIV);
    rst = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'd9; step();
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    for (int t = 0; t < FRAME; t++) begin
      step();
      chk("rst_digits_zero", 32'(bcd), 32'h0);
    end

    // Randomized traffic checked against the frame-time model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 59) != 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_idx = 2'($urandom_range(0, 3));
      wr_data = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scheduler that shares one BCD-to-7-segment decoder across NDIG common-anode digits.
- Holds a small digit register file written by the datapath and steps through the digits at a fixed refresh rate.
- Each scan slot drives the current digit's BCD code to the shared decoder and enables that digit's anode.
- Inserts a blanking gap between slots to prevent ghosting. Sits in top between the datapath and the shared decoder/display pins.

Parameters:
- NDIG, 8, number of digits scanned; legal range 2..8.
- DIV, 50000, clock cycles each digit is shown per slot; must be ≥ 2.
- GAP_CYC, 2, clock cycles of all-anodes-off between slots; must be ≥ 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; 0 = display dark.
- wr_en  input  1  digit register write strobe.
- wr_idx  input  $clog2(NDIG)  digit index to write.
- wr_data  input  4  BCD value to store.
- bcd  output  4  code to the shared decoder.
- an  output  NDIG  anode enables, active-low, one-hot-low when lit.
- frame_tick  output  1  one-cycle pulse at start of each new frame.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst, sampled at posedge clk.
- Reset values: all digit registers = 0, FSM = OFF, idx = 0, cnt = 0, bcd = 0, an = all 1, frame_tick = 0.
- Writes:
  - On a posedge with wr_en=1 and wr_idx<NDIG, digit[wr_idx] <= wr_data.
  - wr_idx≥NDIG is ignored.
  - Writes are accepted in every state.
  - Values 10..15 are stored and passed through unchanged; the decoder defines their glyphs.
- bcd and an are combinational from the registered state and digit file, so a write to the digit currently shown appears on bcd the cycle after the write edge.
- OFF state:
  - Outputs: an = all 1, bcd = 0.
  - en=1 → SHOW with idx=0, cnt=0, and frame_tick=1 on that transition.
- SHOW state:
  - Outputs: an = ~(1<<idx), bcd = digit[idx].
  - cnt increments each cycle; at cnt==DIV-1 → GAP with cnt=0.
- GAP state:
  - Outputs: an = all 1, bcd = digit[idx].
  - At cnt==GAP_CYC-1 → SHOW with cnt=0 and idx advanced.
  - idx advances to idx+1, or wraps to 0 when idx==NDIG-1.
  - frame_tick=1 for one cycle, registered and asserted in the first SHOW cycle of digit 0.
- en=0 in any state → OFF on the next edge, with idx=0 and cnt=0. en low has priority over counter expiry on the same cycle.
- Frame period = NDIG·(DIV+GAP_CYC) cycles.
- rst asserted mid-slot returns to the reset values on the next edge. Digit contents are lost; a write in the same cycle as rst is dropped.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN.
- Defined:
  - Leading-zero blanking is enabled.
  - During SHOW, digit idx>0 is kept dark (an = all 1) when digit[idx] and every higher-index digit equal 0.
  - Digit 0 is always lit.
  - Slot timing is unchanged; only the anode is suppressed.
- Undefined: all digits are always lit in their slot.

Decomposition:
- Package seg_pkg:
  - scan state enum {OFF, SHOW, GAP}.
  - ANODE_OFF constant, all ones.
  - BCD_W=4.
- One natural sub-module: seg_scan_timer. It holds the cnt counter and produces slot_done/gap_done pulses from DIV and GAP_CYC.
- The FSM and digit file stay in seg_scan_ctrl.
- The shared decoder is instantiated in top, not in this block.

Test Plan (NDIG=4, DIV=4, GAP_CYC=1):
- Reset, then write digits 3,1,4,1 to idx 0..3 and raise en.
  - an sequence 1110 (4 cycles), 1111 (1 cycle), 1101, …, 0111.
  - bcd = 3,1,4,1 in the respective slots.
  - frame_tick pulses every 20 cycles.
- en low mid-slot of digit 2: next cycle an=1111, bcd=0. Re-raise en: restarts at digit 0 with frame_tick=1.
- Write digit[1]=7 while digit 1 is shown: bcd changes from 1 to 7 on the following cycle, with no slot restart.
- wr_idx=4 (out of range with NDIG=8 index width, or run NDIG=5 with idx 7): no digit changes.
- rst asserted during GAP: next cycle all reset values, digits read back 0 after en.
- SEG_SCAN_LZB_EN with digits {0,0,5,0} (idx3..0):
  - idx3 slot stays 1111.
  - idx2 is lit with 5.
  - idx1 and idx0 are lit with 0.
